multicycle_control_fsm: RTL and testbench

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/riscv_mc_pkg.sv | 54 +++++
 rtl/ALU_Decoder.sv | 50 +++++
 rtl/multicycle_control_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mc_pkg
// Shared definitions for the multicycle RISC-V control path.
// Contents:
//   state_t        - FSM state encoding (4 bits, FETCH = 0)
//   OP_*           - opcode constants for the supported instruction classes
//   ALUOP_*        - ALUOp codes passed from the FSM to the ALU decoder
//   ALUCTL_*       - ALUControl encoding of the single-cycle core
//   op_supported() - true for every opcode the FSM can execute
// -----------------------------------------------------------------------------
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUCTL_ADD = 3'b000;
    localparam logic [2:0] ALUCTL_SUB = 3'b001;
    localparam logic [2:0] ALUCTL_AND = 3'b010;
    localparam logic [2:0] ALUCTL_OR  = 3'b011;
    localparam logic [2:0] ALUCTL_SLT = 3'b101;

    // An opcode outside this set retires in DECODE without side effects.
    function automatic logic op_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: ok = 1'b1;
            default:                                          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ALU_Decoder.sv
// -----------------------------------------------------------------------------
// ALU_Decoder
// Combinational ALUControl generation shared with the single-cycle core.
// Ports:
//   opb5       in  bit 5 of the opcode (1 for R-type, 0 for I-type ALU ops)
//   funct3     in  instruction funct3 field
//   funct7b5   in  bit 5 of funct7 (selects sub over add for R-type)
//   ALUOp      in  operation class from the control FSM
//   ALUControl out ALU operation select
// -----------------------------------------------------------------------------
module ALU_Decoder
    import riscv_mc_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] ALUOp,
    output logic [2:0] ALUControl
);

    logic rtype_sub_s;

    // Map ALUOp plus function fields onto the ALU operation select.
    always_comb begin
        // addi with immediate bit 10 set must not become sub, hence opb5.
        rtype_sub_s = opb5 & funct7b5;
        ALUControl  = ALUCTL_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALUCTL_ADD;
            ALUOP_SUB: ALUControl = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (rtype_sub_s) begin
                            ALUControl = ALUCTL_SUB;
                        end else begin
                            ALUControl = ALUCTL_ADD;
                        end
                    end
                    3'b010:  ALUControl = ALUCTL_SLT;
                    3'b110:  ALUControl = ALUCTL_OR;
                    3'b111:  ALUControl = ALUCTL_AND;
                    default: ALUControl = ALUCTL_ADD;
                endcase
            end
            default: ALUControl = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
// Moore control FSM of a multicycle RISC-V core with a unified, stallable
// memory. Memory states (FETCH, MEMREAD, MEMWRITE) hold until mem_ready.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   Op, funct3, funct7  fields of the instruction register
//   Zero                ALU zero flag (branch resolution)
//   mem_ready           memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc            datapath mux selects
//   ALUControl          ALU operation select
//   instr_done          one-cycle pulse in the last cycle of each instruction
//   state               current state register (debug)
// -----------------------------------------------------------------------------
module multicycle_control_fsm
    import riscv_mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         Op,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               instr_done,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic [STATE_W-1:0] state
);

    state_t     state_r;
    state_t     next_state_s;

    logic       branch_s;
    logic       pc_update_s;
    logic       ir_write_s;
    logic       mem_write_s;
    logic       reg_write_s;
    logic       instr_done_s;
    logic       adr_src_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;

    // Only funct7[5] influences the ALU; the other bits are deliberately ignored.
    logic       unused_funct7_s;
    assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

    // State register; reset returns to FETCH asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; memory states wait for mem_ready.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = S_EXECUTER;
                    OP_ITYPE:     next_state_s = S_EXECUTEI;
                    OP_BEQ:       next_state_s = S_BEQ;
                    OP_JAL:       next_state_s = S_JAL;
                    default:      next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Op == OP_LW) begin
                    next_state_s = S_MEMREAD;
                end else if (Op == OP_SW) begin
                    next_state_s = S_MEMWRITE;
                end else begin
                    // IR is stable, so this is only reachable by a corrupted state.
                    next_state_s = S_FETCH;
                end
            end
            S_MEMREAD: begin
                if (mem_ready) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMREAD;
                end
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_EXECUTER, S_EXECUTEI, S_JAL: next_state_s = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ:       next_state_s = S_FETCH;
            default:                       next_state_s = S_FETCH;
        endcase
    end

    // Per-state output decode; mem_ready qualifies the memory-completion effects.
    always_comb begin
        branch_s     = 1'b0;
        pc_update_s  = 1'b0;
        ir_write_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        instr_done_s = 1'b0;
        adr_src_s    = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = ALUOP_ADD;
        case (state_r)
            S_FETCH: begin
                // A stalled fetch must neither load the IR nor advance the PC.
                ir_write_s   = mem_ready;
                pc_update_s  = mem_ready;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
            end
            S_DECODE: begin
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b01;
                instr_done_s = ~op_supported(Op);
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_s    = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = mem_ready;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s  = 2'b10;
                alu_op_s     = ALUOP_SUB;
                branch_s     = 1'b1;
                instr_done_s = 1'b1;
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
            end
            default: begin
                branch_s = 1'b0;
            end
        endcase
    end

    // Immediate format select straight from the opcode.
    always_comb begin
        case (Op)
            OP_LW, OP_ITYPE: ImmSrc = 2'b00;
            OP_SW:           ImmSrc = 2'b01;
            OP_BEQ:          ImmSrc = 2'b10;
            OP_JAL:          ImmSrc = 2'b11;
            default:         ImmSrc = 2'b00;
        endcase
    end

    ALU_Decoder u_alu_decoder (
        .opb5       (Op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7[5]),
        .ALUOp      (alu_op_s),
        .ALUControl (ALUControl)
    );

    // While reset is held the state is already FETCH, but FETCH would still
    // follow mem_ready, so every write enable is masked by rst as well.
    assign PCWrite    = rst & ((branch_s & Zero) | pc_update_s);
    assign IRWrite    = rst & ir_write_s;
    assign MemWrite   = rst & mem_write_s;
    assign RegWrite   = rst & reg_write_s;
    assign instr_done = rst & instr_done_s;
    assign AdrSrc     = adr_src_s;
    assign ResultSrc  = result_src_s;
    assign ALUSrcA    = alu_src_a_s;
    assign ALUSrcB    = alu_src_b_s;
    assign state      = STATE_W'(state_r);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Randomized bench: each instruction class is modelled as the list of states
// it walks through; memory states repeat while mem_ready is low. Per-state
// outputs come from a table of the datapath control values.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;
    import riscv_mc_pkg::*;

    logic       clk;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int vectors     = 0;
    int miscompares = 0;

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] ctl_obs;
    logic [4:0]  we_obs;
    assign ctl_obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done,
                      ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
    assign we_obs  = {PCWrite, IRWrite, MemWrite, RegWrite, instr_done};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] alu_funct(input logic [2:0] f3, input logic sub_sel);
        case (f3)
            3'd0:    return sub_sel ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic known_op(input logic [6:0] op);
        return (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
               (op == 7'b0010011) || (op == 7'b1100011) || (op == 7'b1101111);
    endfunction

    // Expected control word, same field order as ctl_obs.
    function automatic logic [16:0] expect_ctl(input state_t st, input logic mr, input logic z,
                                               input logic [6:0] op, input logic [2:0] f3,
                                               input logic [6:0] f7);
        logic pcw, adr, mw, irw, rw, done;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; done = 1'b0;
        rs = 2'd0; sa = 2'd0; sb = 2'd0; alu = 3'd0;
        if (op == 7'b0100011)      imm = 2'd1;
        else if (op == 7'b1100011) imm = 2'd2;
        else if (op == 7'b1101111) imm = 2'd3;
        else                       imm = 2'd0;
        case (st)
            S_FETCH:    begin irw = mr; pcw = mr; sb = 2'd2; rs = 2'd2; end
            S_DECODE:   begin sa = 2'd1; sb = 2'd1; done = !known_op(op); end
            S_MEMADR:   begin sa = 2'd2; sb = 2'd1; end
            S_MEMREAD:  begin adr = 1'b1; end
            S_MEMWRITE: begin adr = 1'b1; mw = 1'b1; done = mr; end
            S_MEMWB:    begin rs = 2'd1; rw = 1'b1; done = 1'b1; end
            S_EXECUTER: begin sa = 2'd2; alu = alu_funct(f3, f7[5]); end
            S_EXECUTEI: begin sa = 2'd2; sb = 2'd1; alu = alu_funct(f3, 1'b0); end
            S_ALUWB:    begin rw = 1'b1; done = 1'b1; end
            S_BEQ:      begin sa = 2'd2; alu = 3'b001; pcw = z; done = 1'b1; end
            S_JAL:      begin sa = 2'd1; sb = 2'd2; pcw = 1'b1; end
            default:    begin pcw = 1'b0; end
        endcase
        return {pcw, adr, mw, irw, rw, done, rs, sa, sb, imm, alu};
    endfunction

    // Runs one instruction of class kind starting at FETCH (called at posedge+1).
    // memwrite_stalls >= 0 forces that many stalled MEMWRITE cycles.
    // abort_memread asserts reset in the first MEMREAD cycle while memory is stalled.
    task automatic run_instr(input int kind, input int memwrite_stalls, input bit abort_memread);
        state_t seq[$];
        logic [6:0] others [5];
        int pos, guard, done_cnt, mw_cnt, mw_cycles;
        state_t cur;
        bit stall;
        others = '{7'b0000000, 7'b0110111, 7'b0010111, 7'b1100111, 7'b1110011};
        seq = {S_FETCH, S_DECODE};
        case (kind)
            0: begin Op = 7'b0000011; seq.push_back(S_MEMADR); seq.push_back(S_MEMREAD); seq.push_back(S_MEMWB); end
            1: begin Op = 7'b0100011; seq.push_back(S_MEMADR); seq.push_back(S_MEMWRITE); end
            2: begin Op = 7'b0110011; seq.push_back(S_EXECUTER); seq.push_back(S_ALUWB); end
            3: begin Op = 7'b0010011; seq.push_back(S_EXECUTEI); seq.push_back(S_ALUWB); end
            4: begin Op = 7'b1100011; seq.push_back(S_BEQ); end
            5: begin Op = 7'b1101111; seq.push_back(S_JAL); seq.push_back(S_ALUWB); end
            default: Op = others[$urandom_range(0, 4)];
        endcase
        case ($urandom_range(0, 4))
            0: funct3 = 3'd0;
            1: funct3 = 3'd2;
            2: funct3 = 3'd6;
            3: funct3 = 3'd7;
            default: funct3 = 3'($urandom_range(0, 7));
        endcase
        funct7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
        if ($urandom_range(0, 3) == 0) funct7 = 7'($urandom_range(0, 127));
        pos = 0; guard = 0; done_cnt = 0; mw_cnt = 0; mw_cycles = 0;
        while (pos < seq.size()) begin
            cur = seq[pos];
            mem_ready = ($urandom_range(0, 3) != 0);
            Zero      = 1'($urandom_range(0, 1));
            if (memwrite_stalls >= 0 && cur == S_MEMWRITE) begin
                mem_ready = (mw_cycles >= memwrite_stalls);
                mw_cycles++;
            end
            if (abort_memread && cur == S_MEMREAD) mem_ready = 1'b0;
            @(negedge clk);
            stall = ((cur == S_FETCH) || (cur == S_MEMREAD) || (cur == S_MEMWRITE)) && !mem_ready;
            check_eq("state", 32'(state), 32'(cur));
            check_eq("ctl", 32'(ctl_obs), 32'(expect_ctl(cur, mem_ready, Zero, Op, funct3, funct7)));
            done_cnt += int'(instr_done);
            mw_cnt   += int'(MemWrite);
            if (abort_memread && cur == S_MEMREAD) begin
                #2 rst = 1'b0;
                #1;
                check_eq("rst_state", 32'(state), 32'(S_FETCH));
                check_eq("rst_we", 32'(we_obs), 32'd0);
                mem_ready = 1'b1;
                #1;
                check_eq("rst_we_ready", 32'(we_obs), 32'd0);
                @(posedge clk); #1;
                check_eq("rst_hold_state", 32'(state), 32'(S_FETCH));
                rst = 1'b1;
                return;
            end
            @(posedge clk); #1;
            if (!stall) pos++;
            guard++;
            if (guard > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout: instruction kind %0d did not retire in 200 cycles", kind);
                return;
            end
        end
        check_eq("done_pulses", 32'(done_cnt), 32'd1);
        if (kind == 1) check_eq("regwrite_sw", 32'(RegWrite), 32'd0);
        if (memwrite_stalls >= 0 && kind == 1)
            check_eq("memwrite_cycles", 32'(mw_cnt), 32'(memwrite_stalls + 1));
    endtask

    initial begin
        rst = 1'b0; Op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; Zero = 1'b0; mem_ready = 1'b1;
        #3;
        check_eq("reset_state", 32'(state), 32'(S_FETCH));
        check_eq("reset_we", 32'(we_obs), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state_clocked", 32'(state), 32'(S_FETCH));
        check_eq("reset_we_clocked", 32'(we_obs), 32'd0);
        rst = 1'b1;

        run_instr(0, -1, 1'b0);
        run_instr(1, 3, 1'b0);
        run_instr(4, -1, 1'b0);
        run_instr(4, -1, 1'b0);
        run_instr(2, -1, 1'b0);
        run_instr(6, -1, 1'b0);
        run_instr(0, -1, 1'b1);
        run_instr(0, -1, 1'b0);
        for (int n = 0; n < 400; n++) begin
            run_instr(int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1,
                      ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
